regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (RegWr/Rw/busW) among NREQ writeback requesters
//  (e.g. ALU, load unit, multiply/divide unit). Uses fair round-robin arbitration with a

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 72 +++++++
 tb/tb_regfile_wb_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Purpose: shared register-file geometry and arbitration helpers for the writeback arbiter.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

   localparam int RF_AW = 5;
   localparam int RF_DW = 32;
   localparam logic [RF_AW-1:0] RF_ZERO = '0;

   // Round-robin successor of a requester index, wrapping at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Purpose: writeback request bundle plus the registered register-file write port.
// Latency: n/a (wires only).
// Backpressure: req_ready per requester; the write port itself has no backpressure.
interface regfile_wb_arbiter_if #(
   parameter int NREQ = 2,
   parameter int AW   = 5,
   parameter int DW   = 32
);
   logic               hold;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               RegWr;
   logic [AW-1:0]      Rw;
   logic [DW-1:0]      busW;
   logic [NREQ-1:0]    grant_q;

   // Writeback sources plus the stall source.
   modport master (
      output hold, req_valid, req_addr, req_data,
      input  req_ready, RegWr, Rw, busW, grant_q
   );

   // Arbiter side.
   modport slave (
      input  hold, req_valid, req_addr, req_data,
      output req_ready, RegWr, Rw, busW, grant_q
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Purpose: combinational round-robin grant starting the scan at ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: en=0 suppresses every grant.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic            en,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_idx
);

   logic found;
   int   cand;

   // Scan ptr, ptr+1, ... mod NREQ; first valid requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (en && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register-file write port among NREQ writeback sources, round-robin.
// Latency: handshake at posedge N drives RegWr/Rw/busW from N to N+1 (1 write per cycle).
// Backpressure: combinational req_ready per requester; hold or reset grants nothing.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW
) (
   input logic                 clk,
   input logic                 reset,
   regfile_wb_arbiter_if.slave bus
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   gnt_idx;
   logic [NREQ-1:0] gnt;
   logic            arb_en;
   logic            grant_any;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   // Nothing is granted during a stall or while reset is asserted.
   assign arb_en    = !bus.hold && !reset;
   assign grant_any = |gnt;
   assign bus.req_ready = gnt;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req     (bus.req_valid),
      .en      (arb_en),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Select only the winner's payload so non-valid lanes never reach the outputs.
   always_comb begin
      sel_addr = bus.req_addr[int'(gnt_idx)*AW +: AW];
      sel_data = bus.req_data[int'(gnt_idx)*DW +: DW];
   end

   // Pointer moves just past the last winner; frozen when nothing is granted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= PW'(wrap_inc(int'(gnt_idx), NREQ));
      end
   end

   // Registered write command; register 0 writes are acknowledged but not enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.RegWr   <= 1'b0;
         bus.Rw      <= '0;
         bus.busW    <= '0;
         bus.grant_q <= '0;
      end else if (grant_any) begin
         bus.RegWr   <= (sel_addr != AW'(RF_ZERO));
         bus.Rw      <= sel_addr;
         bus.busW    <= sel_data;
         bus.grant_q <= gnt;
      end else begin
         bus.RegWr   <= 1'b0;
         bus.grant_q <= '0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: scoreboard bench for regfile_wb_arbiter with NREQ=2 and NREQ=4 instances.
// Latency: expects the write command one posedge after each handshake.
// Backpressure: exercises hold stalls, contention and async reset mid-stream.
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic [3:0]  gnt;
      logic        wr;
      logic [4:0]  rw;
      logic [31:0] bw;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t q2[$];
   exp_t q4[$];

   regfile_wb_arbiter_if #(.NREQ(2), .AW(5), .DW(32)) b2 ();
   regfile_wb_arbiter_if #(.NREQ(4), .AW(5), .DW(32)) b4 ();

   regfile_wb_arbiter #(.NREQ(2), .AW(5), .DW(32)) u2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2.slave)
   );

   regfile_wb_arbiter #(.NREQ(4), .AW(5), .DW(32)) u4 (
      .clk   (clk),
      .reset (reset),
      .bus   (b4.slave)
   );

   // Free-running clock, posedges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] g, input logic w, input logic [4:0] a,
                               input logic [31:0] d);
      exp_t e;
      e.gnt = g;
      e.wr  = w;
      e.rw  = a;
      e.bw  = d;
      return e;
   endfunction

   // One cycle on the NREQ=2 instance: drive, optionally queue expected write, check ready.
   task automatic step2(input logic [1:0] vld, input logic h, input logic [1:0] exp_rdy,
                        input bit push, input exp_t e, input string name);
      b2.req_valid = vld;
      b2.hold      = h;
      if (push) q2.push_back(e);
      @(negedge clk);
      check(name, 64'(b2.req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
   endtask

   // Same for the NREQ=4 instance.
   task automatic step4(input logic [3:0] vld, input logic [3:0] exp_rdy, input int idx,
                        input string name);
      b4.req_valid = vld;
      b4.hold      = 1'b0;
      q4.push_back(mk(exp_rdy, 1'b1, 5'(8 + idx), 32'(32'h100 + idx)));
      @(negedge clk);
      check(name, 64'(b4.req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
   endtask

   // Monitor for NREQ=2: every completed grant must match the next queued expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (b2.grant_q != '0) begin
            if (q2.size() == 0) begin
               check("m2_unexpected_grant", 64'(b2.grant_q), 64'd0);
            end else begin
               exp_t e;
               e = q2.pop_front();
               check("m2_grant_q", 64'(b2.grant_q), 64'(e.gnt));
               check("m2_RegWr", 64'(b2.RegWr), 64'(e.wr));
               check("m2_Rw", 64'(b2.Rw), 64'(e.rw));
               check("m2_busW", 64'(b2.busW), 64'(e.bw));
            end
         end else begin
            check("m2_idle_RegWr", 64'(b2.RegWr), 64'd0);
         end
      end
   end

   // Monitor for NREQ=4.
   always @(negedge clk) begin
      if (!reset) begin
         if (b4.grant_q != '0) begin
            if (q4.size() == 0) begin
               check("m4_unexpected_grant", 64'(b4.grant_q), 64'd0);
            end else begin
               exp_t e;
               e = q4.pop_front();
               check("m4_grant_q", 64'(b4.grant_q), 64'(e.gnt));
               check("m4_RegWr", 64'(b4.RegWr), 64'(e.wr));
               check("m4_Rw", 64'(b4.Rw), 64'(e.rw));
               check("m4_busW", 64'(b4.busW), 64'(e.bw));
            end
         end else begin
            check("m4_idle_RegWr", 64'(b4.RegWr), 64'd0);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      b2.hold      = 1'b0;
      b2.req_valid = 2'b11;
      b2.req_addr  = {5'd5, 5'd3};
      b2.req_data  = {32'hB, 32'h11};
      b4.hold      = 1'b0;
      b4.req_valid = 4'b0000;
      b4.req_addr  = '0;
      b4.req_data  = '0;

      // 1. Reset with both valid: nothing granted, outputs cleared.
      #12;
      check("t1_rst_ready", 64'(b2.req_ready), 64'd0);
      check("t1_rst_RegWr", 64'(b2.RegWr), 64'd0);
      check("t1_rst_grant_q", 64'(b2.grant_q), 64'd0);
      check("t1_rst_ready4", 64'(b4.req_ready), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step2(2'b01, 1'b0, 2'b01, 1'b1, mk(4'b0001, 1'b1, 5'd3, 32'h11), "t1_ready0");

      // 3. Write to register 0 from req1 (ptr=1): acknowledged, RegWr stays low.
      b2.req_addr = {5'd0, 5'd4};
      b2.req_data = {32'hFF, 32'hA};
      step2(2'b10, 1'b0, 2'b10, 1'b1, mk(4'b0010, 1'b0, 5'd0, 32'hFF), "t3_ready1");

      // 2. Contention from ptr=0: grants 0,1,0,1.
      b2.req_addr = {5'd5, 5'd4};
      b2.req_data = {32'hB, 32'hA};
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0)
            step2(2'b11, 1'b0, 2'b01, 1'b1, mk(4'b0001, 1'b1, 5'd4, 32'hA), "t2_ready0");
         else
            step2(2'b11, 1'b0, 2'b10, 1'b1, mk(4'b0010, 1'b1, 5'd5, 32'hB), "t2_ready1");
      end

      // 4. Hold for 3 cycles, then release: ptr still 0 so req0 wins.
      for (int i = 0; i < 3; i++)
         step2(2'b11, 1'b1, 2'b00, 1'b0, mk(4'b0, 1'b0, 5'd0, 32'h0), "t4_hold_ready");
      step2(2'b11, 1'b0, 2'b01, 1'b1, mk(4'b0001, 1'b1, 5'd4, 32'hA), "t4_release");

      // 5. req1 granted next; async reset lands while RegWr=1.
      @(posedge clk);
      #1;
      check("t5_pre_RegWr", 64'(b2.RegWr), 64'd1);
      check("t5_pre_Rw", 64'(b2.Rw), 64'd5);
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_RegWr", 64'(b2.RegWr), 64'd0);
      check("t5_rst_Rw", 64'(b2.Rw), 64'd0);
      check("t5_rst_busW", 64'(b2.busW), 64'd0);
      check("t5_rst_grant_q", 64'(b2.grant_q), 64'd0);
      check("t5_rst_ready", 64'(b2.req_ready), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step2(2'b11, 1'b0, 2'b01, 1'b1, mk(4'b0001, 1'b1, 5'd4, 32'hA), "t5_restart0");
      step2(2'b11, 1'b0, 2'b10, 1'b1, mk(4'b0010, 1'b1, 5'd5, 32'hB), "t5_restart1");
      b2.req_valid = 2'b00;

      // 6. NREQ=4; req0 is idle with unknown payload.
      b4.req_addr = {5'd11, 5'd10, 5'd9, 5'bx};
      b4.req_data = {32'h103, 32'h102, 32'h101, 32'hx};
      step4(4'b1010, 4'b0010, 1, "t6_g1a");
      step4(4'b1010, 4'b1000, 3, "t6_g3a");
      step4(4'b1010, 4'b0010, 1, "t6_g1b");
      step4(4'b1010, 4'b1000, 3, "t6_g3b");
      step4(4'b1110, 4'b0010, 1, "t6_add_g1");
      step4(4'b1110, 4'b0100, 2, "t6_add_g2");
      step4(4'b1110, 4'b1000, 3, "t6_add_g3");
      step4(4'b1110, 4'b0010, 1, "t6_add_g1w");
      b4.req_valid = 4'b0000;

      repeat (3) @(posedge clk);
      #1;
      check("q2_drained", 64'(q2.size()), 64'd0);
      check("q4_drained", 64'(q4.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
